// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for one shared barrel shifter.
// The result is held in an output register, tagged with the requester ID, until it is consumed.

module shifter (
    input  logic [31:0] a,
    input  logic [4:0]  amt,
    input  logic [2:0]  op,
    output logic [31:0] y,
    output logic        err
);

    // Active-low one-hot op decode; any other code yields zero data and an error flag
    always_comb begin
        y   = 32'd0;
        err = 1'b0;
        case (op)
            3'b011:  y = a << amt;
            3'b101:  y = a >> amt;
            3'b110:  y = $signed(a) >>> amt;
            default: err = 1'b1;
        endcase
    end

endmodule

module shift_arbiter #(
    parameter bit REG_IN  = 1'b0,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam state_t ST_AFTER_GRANT = REG_IN ? ST_EXEC : ST_HOLD;

    state_t      state_r;
    state_t      state_next_s;
    logic        ptr_r;
    logic        can_accept_s;
    logic        grant0_s;
    logic        grant1_s;
    logic        grant_s;
    logic        capture_s;
    logic        cap_id_s;
    logic [31:0] sel_a_s;
    logic [4:0]  sel_amt_s;
    logic [2:0]  sel_op_s;
    logic [31:0] opnd_a_r;
    logic [4:0]  opnd_amt_r;
    logic [2:0]  opnd_op_r;
    logic        opnd_id_r;
    logic [31:0] sh_a_s;
    logic [4:0]  sh_amt_s;
    logic [2:0]  sh_op_s;
    logic [31:0] sh_y_s;
    logic        sh_err_s;
    logic        resp_valid_r;
    logic        resp_id_r;
    logic [31:0] resp_data_r;
    logic        resp_err_r;
    logic        unused_s;

    // Upper shift-amount bits are ignored by design
    assign unused_s = ^{req0_b[31:5], req1_b[31:5]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = ST_AFTER_GRANT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (resp_ready) begin
                    if (grant_s) begin
                        state_next_s = ST_AFTER_GRANT;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Grant/ready decode; EXEC never accepts, HOLD accepts only while the result drains
    always_comb begin
        can_accept_s = 1'b0;
        if (!rst) begin
            can_accept_s = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && resp_ready);
        end else begin
            can_accept_s = 1'b0;
        end
        grant0_s   = can_accept_s && req0_valid && (!req1_valid || (ptr_r == 1'b0));
        grant1_s   = can_accept_s && req1_valid && (!req0_valid || (ptr_r == 1'b1));
        req0_ready = grant0_s;
        req1_ready = grant1_s;
    end

    assign grant_s   = grant0_s | grant1_s;
    assign sel_a_s   = grant1_s ? req1_a      : req0_a;
    assign sel_amt_s = grant1_s ? req1_b[4:0] : req0_b[4:0];
    assign sel_op_s  = grant1_s ? req1_op     : req0_op;

    assign sh_a_s    = REG_IN ? opnd_a_r   : sel_a_s;
    assign sh_amt_s  = REG_IN ? opnd_amt_r : sel_amt_s;
    assign sh_op_s   = REG_IN ? opnd_op_r  : sel_op_s;
    assign capture_s = REG_IN ? (state_r == ST_EXEC) : grant_s;
    assign cap_id_s  = REG_IN ? opnd_id_r : grant1_s;

    shifter u_shifter (
        .a   (sh_a_s),
        .amt (sh_amt_s),
        .op  (sh_op_s),
        .y   (sh_y_s),
        .err (sh_err_s)
    );

    // Round-robin pointer: after a grant the other requester gets priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= RR_INIT;
        end else if (grant_s) begin
            ptr_r <= ~grant1_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Operand register, only observed when REG_IN is set
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_a_r   <= 32'd0;
            opnd_amt_r <= 5'd0;
            opnd_op_r  <= 3'b000;
            opnd_id_r  <= 1'b0;
        end else if (grant_s) begin
            opnd_a_r   <= sel_a_s;
            opnd_amt_r <= sel_amt_s;
            opnd_op_r  <= sel_op_s;
            opnd_id_r  <= grant1_s;
        end else begin
            opnd_a_r   <= opnd_a_r;
            opnd_amt_r <= opnd_amt_r;
            opnd_op_r  <= opnd_op_r;
            opnd_id_r  <= opnd_id_r;
        end
    end

    // Response register; contents stay frozen while HOLD waits for the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= (state_next_s == ST_HOLD);
            if (capture_s) begin
                resp_id_r   <= cap_id_s;
                resp_data_r <= sh_y_s;
                resp_err_r  <= sh_err_s;
            end else begin
                resp_id_r   <= resp_id_r;
                resp_data_r <= resp_data_r;
                resp_err_r  <= resp_err_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: dut index 0 has REG_IN=0, dut index 1 has REG_IN=1.
// Stimulus pushes hand-computed responses; a negedge monitor pops them on each consumed result.

module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v0, v1, rdy0, rdy1, rv, rr, rid, rerr;
    logic [31:0] a0[2], b0[2], a1[2], b1[2], rd[2];
    logic [2:0]  o0[2], o1[2];
    logic [33:0] q0[$], q1[$];
    logic [33:0] mon_e;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.REG_IN(1'b0), .RR_INIT(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_op(o0[0]),
        .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_op(o1[0]),
        .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_id(rid[0]), .resp_data(rd[0]), .resp_err(rerr[0])
    );

    shift_arbiter #(.REG_IN(1'b1), .RR_INIT(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_op(o0[1]),
        .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_op(o1[1]),
        .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_id(rid[1]), .resp_data(rd[1]), .resp_err(rerr[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_total++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic push(input int k, input logic err, input logic id, input logic [31:0] d);
        if (k == 0) q0.push_back({err, id, d});
        else        q1.push_back({err, id, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drive one op on dut k / port p, wait for its grant, then check response latency
    task automatic issue(input int k, input int p, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e);
        bit got;
        step();
        push(k, exp_e, p[0], exp_d);
        if (p == 0) begin v0[k] = 1'b1; a0[k] = a; b0[k] = b; o0[k] = op; end
        else        begin v1[k] = 1'b1; a1[k] = a; b1[k] = b; o1[k] = op; end
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((p == 0) ? rdy0[k] : rdy1[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("grant_timeout");
        step();
        if (p == 0) v0[k] = 1'b0;
        else        v1[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("latency1_dut%0d", k), rv[k], (k == 0) ? 1 : 0);
        if (k == 1) begin
            @(negedge clk);
            chk("latency2_dut1", rv[k], 1);
        end
    endtask

    // Scoreboard monitor: every consumed response must match the next expected entry
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (rv[k] && rr[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        flag($sformatf("unexpected_resp_dut%0d", k));
                    end else begin
                        mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("resp_data_dut%0d", k), rd[k], mon_e[31:0]);
                        chk($sformatf("resp_id_dut%0d", k), rid[k], mon_e[32]);
                        chk($sformatf("resp_err_dut%0d", k), rerr[k], mon_e[33]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1;
        v0 = 2'b00; v1 = 2'b00; rr = 2'b11;
        for (int k = 0; k < 2; k++) begin
            a0[k] = 32'd0; b0[k] = 32'd0; o0[k] = 3'b000;
            a1[k] = 32'd0; b1[k] = 32'd0; o1[k] = 3'b000;
        end
        v0[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", rdy0[0], 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid_dut%0d", k), rv[k], 0);
            chk($sformatf("rst_id_dut%0d", k), rid[k], 0);
            chk($sformatf("rst_data_dut%0d", k), rd[k], 0);
            chk($sformatf("rst_err_dut%0d", k), rerr[k], 0);
        end
        step();
        rst = 1'b0;
        v0[0] = 1'b0;

        // Round robin on dut0 with both ports valid
        drain();
        a0[0] = 32'h1;   b0[0] = 32'd1; o0[0] = 3'b011;
        a1[0] = 32'h100; b1[0] = 32'd4; o1[0] = 3'b101;
        for (int i = 0; i < 2; i++) begin
            push(0, 1'b0, 1'b0, 32'h2);
            push(0, 1'b0, 1'b1, 32'h10);
        end
        v0[0] = 1'b1; v1[0] = 1'b1;
        g = 0;
        for (int c = 0; c < 20 && g < 4; c++) begin
            @(negedge clk);
            chk("one_ready", rdy0[0] & rdy1[0], 0);
            if (rdy0[0] | rdy1[0]) begin
                chk($sformatf("rr_grant%0d", g), rdy1[0], g[0]);
                g++;
                if (g == 4) begin
                    step();
                    v0[0] = 1'b0; v1[0] = 1'b0;
                end
            end
        end
        if (g < 4) flag("rr_grants_missing");

        // Basic ops, masking, zero shift, illegal op on dut0
        drain();
        issue(0, 0, 3'b011, 32'h00000001, 32'd5,        32'h00000020, 1'b0);
        issue(0, 0, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 1'b0);
        issue(0, 0, 3'b110, 32'h80000000, 32'd4,        32'hF8000000, 1'b0);
        issue(0, 1, 3'b011, 32'h0000000F, 32'h00000025, 32'h000001E0, 1'b0);
        issue(0, 0, 3'b011, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0);
        issue(0, 1, 3'b101, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0);
        issue(0, 0, 3'b110, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0);
        issue(0, 1, 3'b000, 32'h00001234, 32'd3,        32'h00000000, 1'b1);

        // Backpressure and back-to-back grant on dut0
        drain();
        rr[0] = 1'b0;
        push(0, 1'b0, 1'b0, 32'hC);
        v0[0] = 1'b1; a0[0] = 32'h3; b0[0] = 32'd2; o0[0] = 3'b011;
        @(negedge clk);
        chk("bp_first_grant", rdy0[0], 1);
        step();
        v0[0] = 1'b0;
        push(0, 1'b0, 1'b1, 32'hF);
        v1[0] = 1'b1; a1[0] = 32'hF0; b1[0] = 32'd4; o1[0] = 3'b101;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", rv[0], 1);
            chk("bp_data", rd[0], 32'hC);
            chk("bp_id", rid[0], 0);
            chk("bp_ready", {rdy0[0], rdy1[0]}, 0);
        end
        step();
        rr[0] = 1'b1;
        @(negedge clk);
        chk("b2b_grant", rdy1[0], 1);
        step();
        v1[0] = 1'b0;
        @(negedge clk);
        chk("b2b_valid", rv[0], 1);

        // REG_IN=1: two-cycle latency, no grant while in EXEC
        drain();
        push(1, 1'b0, 1'b0, 32'hFFFFFFFF);
        push(1, 1'b0, 1'b1, 32'h2);
        v0[1] = 1'b1; a0[1] = 32'hFFFF0000; b0[1] = 32'd16; o0[1] = 3'b110;
        v1[1] = 1'b1; a1[1] = 32'h1;        b1[1] = 32'd1;  o1[1] = 3'b011;
        @(negedge clk);
        chk("r1_grant0", {rdy0[1], rdy1[1]}, 2'b10);
        step();
        v0[1] = 1'b0;
        @(negedge clk);
        chk("r1_exec_valid", rv[1], 0);
        chk("r1_exec_no_grant", rdy1[1], 0);
        @(negedge clk);
        chk("r1_hold_valid", rv[1], 1);
        chk("r1_b2b_grant1", rdy1[1], 1);
        step();
        v1[1] = 1'b0;
        @(negedge clk);
        chk("r1_exec2_valid", rv[1], 0);
        @(negedge clk);
        chk("r1_hold2_valid", rv[1], 1);
        issue(1, 0, 3'b111, 32'h12345678, 32'd1, 32'h00000000, 1'b1);
        issue(1, 1, 3'b101, 32'hF0F0F0F0, 32'h24, 32'h0F0F0F0F, 1'b0);

        // Reset with dut0 in HOLD and dut1 in EXEC
        drain();
        rr[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v0[k] = 1'b1; a0[k] = 32'h1; b0[k] = 32'd1; o0[k] = 3'b011;
        end
        @(negedge clk);
        chk("pre_rst_grants", rdy0, 2'b11);
        step();
        rst = 1'b1;
        v0 = 2'b00;
        @(negedge clk);
        chk("pre_rst_states", rv, 2'b01);
        step();
        rst = 1'b0;
        rr = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale_resp", rv, 2'b00);
        end
        step();
        push(0, 1'b0, 1'b0, 32'h2);
        v0[0] = 1'b1; v1[0] = 1'b1;
        @(negedge clk);
        chk("ptr_after_rst", {rdy0[0], rdy1[0]}, 2'b10);
        step();
        v0[0] = 1'b0; v1[0] = 1'b0;
        drain();
        @(negedge clk);
        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational `shifter` datapath instance between two requesters, port 0 and port 1 (e.g. the execute-stage ALU path and a secondary unit).
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Holds each result in an output register until it is consumed, tagged with the requester ID.
- Sits between the issue logic and writeback; the shifter instance is internal to this block.

Parameters:
- REG_IN, default 0: 0 = result captured in the grant cycle (latency 1); 1 = operands registered first, result captured next cycle (latency 2).
- RR_INIT, default 0: requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 has an operation.
- req0_ready  output  1  port 0 operation accepted this cycle.
- req0_a  input  32  port 0 operand to shift.
- req0_b  input  32  port 0 shift amount; only [4:0] is used.
- req0_op  input  3  port 0 op, active-LOW one-hot: 3'b011 = sll, 3'b101 = srl, 3'b110 = sra.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for port 1.
- resp_valid  output  1  result register holds a result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that issued the result.
- resp_data  output  32  shift result.
- resp_err  output  1  op was not one of the three legal codes.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0.
  - req0_ready = req1_ready = 0.
  - Priority pointer = RR_INIT.
  - Any in-flight operation is discarded; no response is emitted for it.
- States: IDLE, EXEC (only reachable when REG_IN = 1), HOLD.
- Grant conditions:
  - A grant occurs only when the block can accept: state is IDLE, or state is HOLD with resp_ready = 1 in the same cycle (back-to-back).
  - EXEC never grants.
- Arbitration:
  - One requester valid: it is granted.
  - Both valid: the priority-pointer requester is granted.
  - After every grant the pointer moves to the non-granted requester.
  - req_ready is combinational from state, valids and pointer. At most one ready is high per cycle. Ready is never high for a requester whose valid is low.
- Datapath: the granted operands and op drive the shifter. When REG_IN = 1, they come from the operand register instead.
- REG_IN = 0:
  - Grant cycle: resp_data ← shifter output, resp_id ← granted ID.
  - Next state HOLD; resp_valid = 1 from the next cycle.
- REG_IN = 1:
  - Grant cycle: latch a, b[4:0], op and ID into the operand register; next state EXEC.
  - EXEC: capture the result; next state HOLD.
- HOLD:
  - resp_valid = 1, and resp_data, resp_id, resp_err are stable until resp_ready = 1.
  - resp_ready = 1 with a new grant (REG_IN = 0): stay in HOLD with the new result.
  - resp_ready = 1 with a new grant (REG_IN = 1): go to EXEC.
  - resp_ready = 1 with no grant: go to IDLE; resp_valid = 0 next cycle.
- Illegal op (not 011, 101 or 110):
  - Operation is still granted and completes normally.
  - resp_data = 0, resp_err = 1.
- Shift amount: only b[4:0] is used. b = 0 returns a unchanged for all ops.
- Throughput: REG_IN = 0 allows one result per cycle when resp_ready is held high. REG_IN = 1 allows one result per 2 cycles.
- Requester rule: a requester must hold its valid and operands until it sees ready. The block does not check this.

Test Plan:
- Basic ops, REG_IN = 0, port 0 only:
  - sll, a = 0x00000001, b = 5 → resp_data = 0x00000020, resp_id = 0, one cycle after the grant.
  - srl, a = 0x80000000, b = 4 → 0x08000000.
  - sra, a = 0x80000000, b = 4 → 0xF8000000.
- Amount masking and zero shift:
  - sll, a = 0x0000000F, b = 0x00000025 → 0x000001E0.
  - b = 0 with each op, a = 0xDEADBEEF → 0xDEADBEEF.
- Round-robin:
  - Both ports valid continuously, resp_ready = 1, RR_INIT = 0 → grants alternate 0,1,0,1; resp_id follows the same sequence; never two readys in one cycle.
- Backpressure:
  - resp_ready = 0 for 5 cycles with a result held → resp_data and resp_id stable; req0_ready = req1_ready = 0.
  - Raising resp_ready with a request pending → back-to-back grant in that same cycle.
- REG_IN = 1:
  - sra, a = 0xFFFF0000, b = 16 → resp_valid two cycles after the grant, resp_data = 0xFFFFFFFF; no grant while in EXEC.
- Illegal op and reset:
  - op = 3'b000 → resp_err = 1, resp_data = 0.
  - Assert rst while in EXEC or HOLD → next cycle resp_valid = 0, IDLE, pointer = RR_INIT; no stale response afterwards.
